// File: rtl/vm2002_common_pkg.sv
// Shared types and coin constants for the vm2002 change-return path.
// Coin codes double as eject solenoid selects; code 0 means no coin.
package vm2002_common_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_EJECT  = 3'd2,
    ST_DONE   = 3'd3,
    ST_JAM    = 3'd4
  } change_state_t;

  typedef enum logic [1:0] {
    COIN_NONE    = 2'd0,
    COIN_NICKEL  = 2'd1,
    COIN_DIME    = 2'd2,
    COIN_QUARTER = 2'd3
  } coins_t;

  localparam logic [4:0] COIN_VAL_NICKEL  = 5'd5;
  localparam logic [4:0] COIN_VAL_DIME    = 5'd10;
  localparam logic [4:0] COIN_VAL_QUARTER = 5'd25;

  function automatic logic [4:0] coin_value(input coins_t coin);
    logic [4:0] val;
    case (coin)
      COIN_NICKEL:  val = COIN_VAL_NICKEL;
      COIN_DIME:    val = COIN_VAL_DIME;
      COIN_QUARTER: val = COIN_VAL_QUARTER;
      default:      val = 5'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/vm2002_coin_tube.sv
// One coin-tube inventory: saturating refill add, single-coin decrement.
// o_sat flags an add whose sum would exceed the tube capacity.
module vm2002_coin_tube
  import vm2002_common_pkg::*;
#(
  parameter int TUBE_W   = 6,
  parameter int TUBE_MAX = 50
) (
  input  logic              i_clk,
  input  logic              i_hrst,
  input  logic              i_add_en,
  input  logic [TUBE_W-1:0] i_add_cnt,
  input  logic              i_dec_en,
  output logic [TUBE_W-1:0] o_cnt,
  output logic              o_sat
);

  localparam logic [TUBE_W:0]   L_MAX_W = (TUBE_W + 1)'(TUBE_MAX);
  localparam logic [TUBE_W-1:0] L_MAX   = TUBE_W'(TUBE_MAX);

  logic [TUBE_W-1:0] r_cnt;
  logic [TUBE_W:0]   w_sum;

  assign w_sum = {1'b0, r_cnt} + {1'b0, i_add_cnt};
  assign o_sat = i_add_en && (w_sum > L_MAX_W);
  assign o_cnt = r_cnt;

  // Tube inventory register
  always_ff @(posedge i_clk) begin
    if (i_hrst) begin
      r_cnt <= {TUBE_W{1'b0}};
    end else if (i_add_en) begin
      r_cnt <= o_sat ? L_MAX : w_sum[TUBE_W-1:0];
    end else if (i_dec_en && (r_cnt != {TUBE_W{1'b0}})) begin
      r_cnt <= r_cnt - {{(TUBE_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/vm2002_change_ctrl.sv
// Change-return sequencer: pays a balance greedily (Q > D > N) one coin at a
// time from three finite tubes, reports any unpaid residue, latches ack jams.
module vm2002_change_ctrl
  import vm2002_common_pkg::*;
#(
  parameter int AMT_W    = 16,
  parameter int TUBE_W   = 6,
  parameter int TUBE_MAX = 50,
  parameter int ACK_TO   = 255
) (
  input  logic              clk,
  input  logic              hrst,
  input  logic              req_valid,
  input  logic [AMT_W-1:0]  req_amount,
  output logic              req_ready,
  input  logic              refill_valid,
  input  logic [1:0]        refill_coin,
  input  logic [TUBE_W-1:0] refill_count,
  output logic              refill_err,
  output logic [1:0]        eject_coin,
  input  logic              eject_ack,
  output logic              done,
  output logic [AMT_W-1:0]  short_amount,
  output logic              jam,
  output logic [TUBE_W-1:0] nickel_cnt,
  output logic [TUBE_W-1:0] dime_cnt,
  output logic [TUBE_W-1:0] quarter_cnt
);

  localparam int              TO_W   = $clog2(ACK_TO + 1);
  localparam logic [TO_W-1:0] L_TO   = TO_W'(ACK_TO);
  localparam logic [AMT_W-1:0] L_VAL_N = AMT_W'(COIN_VAL_NICKEL);
  localparam logic [AMT_W-1:0] L_VAL_D = AMT_W'(COIN_VAL_DIME);
  localparam logic [AMT_W-1:0] L_VAL_Q = AMT_W'(COIN_VAL_QUARTER);

  change_state_t    r_state;
  coins_t           r_coin;
  coins_t           r_eject_coin;
  logic [AMT_W-1:0] r_remaining;
  logic [AMT_W-1:0] r_short;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_done;
  logic             r_jam;
  logic             r_refill_err;

  coins_t w_refill_coin;
  logic   w_idle, w_accept, w_refill_ok, w_refill_drop, w_ack;
  logic   w_add_n, w_add_d, w_add_q, w_dec_n, w_dec_d, w_dec_q;
  logic   w_sat_n, w_sat_d, w_sat_q;

  assign w_refill_coin = coins_t'(refill_coin);
  assign w_idle        = (r_state == ST_IDLE);
  assign w_accept      = req_valid && w_idle;
  // A coincident request always wins over a refill in IDLE.
  assign w_refill_ok   = refill_valid && w_idle && !req_valid && (w_refill_coin != COIN_NONE);
  assign w_refill_drop = refill_valid && !w_refill_ok;
  assign w_add_n       = w_refill_ok && (w_refill_coin == COIN_NICKEL);
  assign w_add_d       = w_refill_ok && (w_refill_coin == COIN_DIME);
  assign w_add_q       = w_refill_ok && (w_refill_coin == COIN_QUARTER);
  assign w_ack         = (r_state == ST_EJECT) && eject_ack;
  assign w_dec_n       = w_ack && (r_coin == COIN_NICKEL);
  assign w_dec_d       = w_ack && (r_coin == COIN_DIME);
  assign w_dec_q       = w_ack && (r_coin == COIN_QUARTER);

  vm2002_coin_tube #(.TUBE_W(TUBE_W), .TUBE_MAX(TUBE_MAX)) u_tube_n (
    .i_clk(clk), .i_hrst(hrst), .i_add_en(w_add_n), .i_add_cnt(refill_count),
    .i_dec_en(w_dec_n), .o_cnt(nickel_cnt), .o_sat(w_sat_n));
  vm2002_coin_tube #(.TUBE_W(TUBE_W), .TUBE_MAX(TUBE_MAX)) u_tube_d (
    .i_clk(clk), .i_hrst(hrst), .i_add_en(w_add_d), .i_add_cnt(refill_count),
    .i_dec_en(w_dec_d), .o_cnt(dime_cnt), .o_sat(w_sat_d));
  vm2002_coin_tube #(.TUBE_W(TUBE_W), .TUBE_MAX(TUBE_MAX)) u_tube_q (
    .i_clk(clk), .i_hrst(hrst), .i_add_en(w_add_q), .i_add_cnt(refill_count),
    .i_dec_en(w_dec_q), .o_cnt(quarter_cnt), .o_sat(w_sat_q));

  assign req_ready    = w_idle;
  assign refill_err   = r_refill_err;
  assign eject_coin   = r_eject_coin;
  assign done         = r_done;
  assign short_amount = r_short;
  assign jam          = r_jam;

  // Refill error pulse: dropped refills and saturating adds
  always_ff @(posedge clk) begin
    if (hrst) begin
      r_refill_err <= 1'b0;
    end else begin
      r_refill_err <= w_refill_drop || w_sat_n || w_sat_d || w_sat_q;
    end
  end

  // Change FSM with remaining balance and ack timeout
  always_ff @(posedge clk) begin
    if (hrst) begin
      r_state      <= ST_IDLE;
      r_coin       <= COIN_NONE;
      r_eject_coin <= COIN_NONE;
      r_remaining  <= {AMT_W{1'b0}};
      r_short      <= {AMT_W{1'b0}};
      r_to_cnt     <= {TO_W{1'b0}};
      r_done       <= 1'b0;
      r_jam        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_remaining <= req_amount;
            r_short     <= {AMT_W{1'b0}};
            r_state     <= (req_amount == {AMT_W{1'b0}}) ? ST_DONE : ST_SELECT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SELECT: begin
          r_to_cnt <= {TO_W{1'b0}};
          if ((r_remaining >= L_VAL_Q) && (quarter_cnt != {TUBE_W{1'b0}})) begin
            r_coin <= COIN_QUARTER; r_eject_coin <= COIN_QUARTER; r_state <= ST_EJECT;
          end else if ((r_remaining >= L_VAL_D) && (dime_cnt != {TUBE_W{1'b0}})) begin
            r_coin <= COIN_DIME; r_eject_coin <= COIN_DIME; r_state <= ST_EJECT;
          end else if ((r_remaining >= L_VAL_N) && (nickel_cnt != {TUBE_W{1'b0}})) begin
            r_coin <= COIN_NICKEL; r_eject_coin <= COIN_NICKEL; r_state <= ST_EJECT;
          end else begin
            r_short <= r_remaining;
            r_state <= ST_DONE;
          end
        end
        ST_EJECT: begin
          if (eject_ack) begin
            r_remaining  <= r_remaining - AMT_W'(coin_value(r_coin));
            r_eject_coin <= COIN_NONE;
            r_state      <= ST_SELECT;
          end else if (r_to_cnt == L_TO) begin
            r_eject_coin <= COIN_NONE;
            r_short      <= r_remaining;
            r_jam        <= 1'b1;
            r_state      <= ST_JAM;
          end else begin
            r_to_cnt <= r_to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          r_done      <= 1'b1;
          r_remaining <= {AMT_W{1'b0}};
          r_state     <= ST_IDLE;
        end
        ST_JAM: begin
          r_jam        <= 1'b1;
          r_eject_coin <= COIN_NONE;
          r_state      <= ST_JAM;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/vm2002_change_ctrl.md
Name: vm2002_change_ctrl

Overview:
- Sequences the return of change after a vend.
- Accepts a balance in cents from the vend FSM and drives the coin-ejector solenoids one coin at a time, greedy order quarter > dime > nickel.
- Tracks finite coin-tube inventories, which the supplier refills, and reports any amount it could not pay.
- Sits between the vend FSM (balance producer) and the coin-return mechanism.

Parameters:
- AMT_W, 16, width of amount/balance in cents.
- TUBE_W, 6, width of each coin-tube counter.
- TUBE_MAX, 50, maximum coins per tube (must be <= 2**TUBE_W-1).
- ACK_TO, 255, cycles to wait for eject_ack before declaring a jam.

Ports:
- clk  in  1  system clock
- hrst  in  1  reset; one clock; synchronous, active-high
- req_valid  in  1  change request
- req_amount  in  AMT_W  balance to return, in cents
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
- refill_valid  in  1  supplier loads coins into a tube
- refill_coin  in  2  coins_t code (NICKEL/DIME/QUARTER)
- refill_count  in  TUBE_W  coins added
- refill_err  out  1  1-cycle pulse: refill rejected or saturated
- eject_coin  out  2  coins_t code of the coin being ejected; 0 when idle
- eject_ack  in  1  mechanism confirms the coin dropped
- done  out  1  1-cycle pulse when the request completes
- short_amount  out  AMT_W  unpaid cents of the last request; held until the next accept
- jam  out  1  sticky fault: ack timeout
- nickel_cnt, dime_cnt, quarter_cnt  out  TUBE_W each  tube inventories

Behaviour:
- Reset (hrst=1 at posedge): state=IDLE; all tube counts=0; remaining=0; short_amount=0; eject_coin=0; done=0; refill_err=0; jam=0; timeout counter=0. hrst overrides everything, including mid-eject.
- States: IDLE, SELECT, EJECT, DONE, JAM.
- IDLE:
  - req_ready=1.
  - On accept: remaining<=req_amount; go to SELECT the next cycle.
  - req_amount=0: accepted; go straight to DONE (done pulses 2 cycles after accept, short_amount=0).
- SELECT (1 cycle):
  - remaining>=25 && quarter_cnt>0 → QUARTER.
  - Else remaining>=10 && dime_cnt>0 → DIME.
  - Else remaining>=5 && nickel_cnt>0 → NICKEL.
  - Else: short_amount<=remaining; go to DONE.
  - On a selection: latch the coin, clear the timeout counter, go to EJECT.
- EJECT:
  - eject_coin=latched code, held stable until ack.
  - On eject_ack: remaining-=value; decrement that tube; go to SELECT.
  - If the timeout counter reaches ACK_TO without ack: go to JAM, short_amount<=remaining.
  - eject_ack outside EJECT is ignored.
- DONE: done=1 for exactly one cycle; remaining<=0; return to IDLE.
- JAM: jam=1, eject_coin=0, req_ready=0; exit only via hrst.
- Arithmetic:
  - remaining is unsigned AMT_W; subtraction cannot underflow because of the >= guards.
  - A residue that is not a multiple of 5 always ends in short_amount.
- Refill:
  - Applied only in IDLE with no simultaneous accepted request.
  - If req_valid and refill_valid coincide in IDLE, the request wins; refill is dropped and refill_err pulses.
  - Refill in any other state is dropped with refill_err.
  - Sum > TUBE_MAX: tube saturates at TUBE_MAX and refill_err pulses.
  - Invalid code (0): dropped with refill_err.
- Latency: accept → first eject_coin nonzero = 2 cycles; each coin costs 1 SELECT cycle plus the ack wait.

Decomposition:
- vm2002_common_pkg: change_state_t enum, coins_t (existing), and COIN_VAL_NICKEL=5, COIN_VAL_DIME=10, COIN_VAL_QUARTER=25 constants.
- Sub-module vm2002_coin_tube, instantiated x3: one saturating up/down counter with add/dec/err.
- Top holds the FSM, remaining register and ack-timeout counter.

Test Plan:
- Refill 4 quarters, 4 dimes, 4 nickels; request 65 with eject_ack 3 cycles after each eject → ejects Q,Q,D,N; done pulses; short_amount=0; counts Q=2, D=3, N=3.
- Tubes Q=0, D=1, N=1; request 40 → ejects D,N; short_amount=25; done pulses.
- Request 7 with all tubes full → ejects N; short_amount=2.
- Request 25; withhold eject_ack for ACK_TO cycles → jam=1; short_amount=25; req_ready=0; then hrst → all outputs reset, counts=0.
- Refill nickel_cnt 45 + 10 → nickel_cnt=50; refill_err pulses once. A refill during EJECT → dropped, refill_err pulses.
- Request 0 → done 2 cycles after accept, no eject. Assert hrst mid-EJECT → state IDLE, eject_coin=0 the next cycle.
